// File: rtl/count_checker.sv
// Receive-side checker for an up/down counter stream: locks, flags errors, reports wraps.
// Optional CHK_HOLD_EN: a repeated value is a hold (hold_pulse), not a mismatch.
module count_checker #(
  parameter int WIDTH    = 16,
  parameter int ERR_W    = 8,
  parameter int SYNC_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             dir_in,
  input  logic             valid_in,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             wrap_up,
  output logic             wrap_down,
`ifdef CHK_HOLD_EN
  output logic             hold_pulse,
`endif
  output logic [WIDTH-1:0] expected
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] SYNC_TGT = 4'(SYNC_LEN);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [3:0]       sync_q, sync_d;
  logic             locked_d;
  logic             err_pulse_d;
  logic [ERR_W-1:0] err_count_d;
  logic             wrap_up_d;
  logic             wrap_down_d;
  logic [WIDTH-1:0] expected_d;
  logic             hold_d;
  logic [WIDTH-1:0] pred;
  logic             consistent;
  logic             is_hold;

  assign pred = dir_in ? ref_q - WIDTH'(1)
                       : ref_q + WIDTH'(1);
  assign consistent = (cnt_in == pred);

`ifdef CHK_HOLD_EN
  assign is_hold = valid_in && (state_q != EMPTY)
                && (cnt_in == ref_q);
`else
  assign is_hold = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    sync_d      = sync_q;
    locked_d    = locked;
    err_pulse_d = 1'b0;
    err_count_d = err_count;
    wrap_up_d   = 1'b0;
    wrap_down_d = 1'b0;
    expected_d  = expected;
    hold_d      = 1'b0;
    if (clear) begin
      state_d     = EMPTY;
      ref_d       = '0;
      sync_d      = '0;
      locked_d    = 1'b0;
      err_count_d = '0;
      expected_d  = '0;
    end else if (valid_in) begin
      if (is_hold) begin
        hold_d = 1'b1;
      end else begin
        ref_d = cnt_in;
        unique case (state_q)
          EMPTY: begin
            sync_d  = '0;
            state_d = SYNC;
          end
          SYNC: begin
            expected_d = pred;
            if (consistent) begin
              sync_d = sync_q + 4'd1;
              if (sync_q + 4'd1 == SYNC_TGT) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
              end
            end else begin
              sync_d = '0;
            end
          end
          LOCKED: begin
            expected_d = pred;
            if (!consistent) begin
              err_pulse_d = 1'b1;
              if (err_count != '1)
                err_count_d = err_count + ERR_W'(1);
              locked_d = 1'b0;
              sync_d   = '0;
              state_d  = SYNC;
            end
          end
          default: state_d = EMPTY;
        endcase
        // wrap only counts on a consistent step from a held reference
        if (state_q != EMPTY && consistent) begin
          wrap_up_d   = !dir_in && (ref_q == '1)
                      && (cnt_in == '0);
          wrap_down_d = dir_in && (ref_q == '0)
                      && (cnt_in == '1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      ref_q     <= '0;
      sync_q    <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      wrap_up   <= 1'b0;
      wrap_down <= 1'b0;
      expected  <= '0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      sync_q    <= sync_d;
      locked    <= locked_d;
      err_pulse <= err_pulse_d;
      err_count <= err_count_d;
      wrap_up   <= wrap_up_d;
      wrap_down <= wrap_down_d;
      expected  <= expected_d;
    end
  end

`ifdef CHK_HOLD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hold_pulse <= 1'b0;
    else      hold_pulse <= hold_d;
  end
`else
  logic unused_hold;
  assign unused_hold = hold_d;
`endif

endmodule

// File: doc/count_checker.md
Name: count_checker

Overview:
- Receive-side monitor for the 16-bit up/down counter stream: the count value plus the registered direction flag.
- On every valid sample, predicts the next value from the previous sample and the direction flag.
- Locks after a run of consistent samples, then flags mismatches, counts errors and reports wrap-around events.
- Sits downstream of the counter as its consumer/checker, in the same clock domain.

Parameters:
- WIDTH, 16, width of the count stream.
- ERR_W, 8, width of the saturating error counter.
- SYNC_LEN, 2, consecutive consistent transitions required to enter LOCKED (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- cnt_in  input  WIDTH  sampled count value.
- dir_in  input  1  direction that produced cnt_in: 1 = decrement, 0 = increment.
- valid_in  input  1  sample qualifier; cnt_in/dir_in are ignored when low.
- clear  input  1  synchronous clear of state and err_count; highest priority after reset.
- locked  output  1  high while the FSM is in LOCKED.
- err_pulse  output  1  one-cycle pulse on a mismatch detected in LOCKED.
- err_count  output  ERR_W  saturating mismatch count.
- wrap_up  output  1  one-cycle pulse on a consistent increment from all-ones to 0.
- wrap_down  output  1  one-cycle pulse on a consistent decrement from 0 to all-ones.
- expected  output  WIDTH  value the checker predicted for the last accepted sample.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM = EMPTY, ref = 0, sync_cnt = 0.
  - All outputs 0.
- All outputs are registered. Response appears the cycle after the sample edge (latency 1).
- Pulse outputs are high for exactly one cycle, and only in the cycle after a valid sample.
- Prediction for a valid sample: pred = dir_in ? ref - 1 : ref + 1, computed modulo 2^WIDTH. ref is the previous accepted cnt_in.
  - consistent = (cnt_in == pred).
- expected <= pred on every valid sample in SYNC or LOCKED. Unchanged otherwise.
- FSM states:
  - EMPTY: no reference held. A valid sample loads ref <= cnt_in, sync_cnt <= 0, next state SYNC. No pulses.
  - SYNC:
    - Consistent sample: sync_cnt++; when sync_cnt reaches SYNC_LEN, go to LOCKED and set locked = 1.
    - Inconsistent sample: sync_cnt <= 0, stay in SYNC, no err_pulse.
    - ref <= cnt_in on every valid sample.
  - LOCKED:
    - Consistent sample: stay in LOCKED.
    - Inconsistent sample: err_pulse = 1, err_count++ (saturating at all-ones), locked <= 0, sync_cnt <= 0, go to SYNC.
    - ref <= cnt_in on every valid sample, so the bad value becomes the new reference.
- Wrap pulses:
  - Asserted only for consistent samples, in SYNC or LOCKED.
  - wrap_up when dir_in = 0, ref = all-ones, cnt_in = 0.
  - wrap_down when dir_in = 1, ref = 0, cnt_in = all-ones.
- valid_in low: no state change; pulses deassert.
- Direction reversal (dir_in toggling between samples) is legal; only the value relation matters.
- clear high:
  - Same effect as reset except it is synchronous.
  - Overrides a simultaneous valid sample; that sample is discarded.
- Reset mid-operation: immediate return to the reset state, including err_count = 0.
- err_count saturated: further errors still pulse err_pulse; the count holds.

Optional Feature:
- Macro CHK_HOLD_EN.
- Defined: a valid sample with cnt_in == ref is a hold, not a mismatch:
  - no state change, sync_cnt unchanged, no pulses, expected unchanged;
  - extra output hold_pulse (1 bit, reset 0) pulses one cycle per hold.
- Not defined: such a sample is evaluated normally, i.e. it is an inconsistent sample. No hold_pulse port.

Test Plan:
- Reset release, then increment stream 0x0005, 0x0006, 0x0007 with dir_in = 0 and SYNC_LEN = 2 -> locked = 1 the cycle after the 0x0007 sample; err_count = 0.
- Locked increment stream 0xFFFE, 0xFFFF, 0x0000 -> single wrap_up pulse after 0x0000; expected = 0x0000.
- Locked, dir_in = 1, stream 0x0001, 0x0000, 0xFFFF -> single wrap_down pulse; no err_pulse.
- Locked at 0x0010, inject 0x0020 (dir_in = 0) -> err_pulse one cycle, err_count = 1, locked = 0. Then 0x0021, 0x0022 -> relocked.
- 300 injected errors with ERR_W = 8 -> err_count holds at 0xFF; err_pulse still fires on each error. Then clear for one cycle together with a valid sample -> err_count = 0, state EMPTY, sample ignored.
- CHK_HOLD_EN defined, locked at 0x0100, repeat 0x0100 -> hold_pulse, locked stays 1, no error. Without the macro, the same stimulus -> err_pulse, err_count = 1.
